// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared binary/Gray conversion helpers
// Purpose: common conversion functions for the Gray pointer encode and decode
//   paths. Functions work on a fixed maximum width; callers zero-extend their
//   SIZE-bit value in and truncate the result, which is exact for both directions
//   because the extra high bits are zero.
// Ports: none (package).
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR-prefix from the MSB down: b[i] = g[MSB] ^ ... ^ g[i]
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// rtl/gray_counter_if.sv - control and count bus of the Gray counter
// Purpose: bundles the step/load controls and the registered count outputs.
// Signals:
//   en, up, load, load_val : controls driven by the master side
//   bin_out, gray_out, wrap: registered results driven by the counter (slave)
interface gray_counter_if #(
  parameter int SIZE = 4
);

  logic            en;
  logic            up;
  logic            load;
  logic [SIZE-1:0] load_val;
  logic [SIZE-1:0] bin_out;
  logic [SIZE-1:0] gray_out;
  logic            wrap;

  modport master (
    output en, up, load, load_val,
    input  bin_out, gray_out, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output bin_out, gray_out, wrap
  );

endinterface

// File: rtl/bin_to_gray.sv
// rtl/bin_to_gray.sv - combinational binary to Gray encoder
// Purpose: g = b ^ (b >> 1), used on the next-state value so the Gray output
//   can be taken directly from a flop.
// Ports:
//   i_bin  in  SIZE  binary value
//   o_gray out SIZE  Gray code of i_bin
module bin_to_gray #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] i_bin,
  output logic [SIZE-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down counter with registered Gray copy
// Purpose: modular SIZE-bit up/down counter with load; drives a flop-sourced
//   Gray code of the count (safe to synchronise into another clock domain)
//   and a one-cycle wrap pulse.
// Ports:
//   clk  in  1   clock, rising edge
//   rst  in  1   synchronous reset, active-high
//   bus  slave   en/up/load/load_val in; bin_out/gray_out/wrap out
module gray_counter
  import gray_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  gray_counter_if.slave bus
);

  localparam logic [SIZE-1:0] RESET_BIN  = SIZE'(RESET_VAL);
  localparam logic [SIZE-1:0] RESET_GRAY = SIZE'(bin2gray(GRAY_MAX_W'(RESET_BIN)));

  logic [SIZE-1:0] r_bin_q;
  logic [SIZE-1:0] r_gray_q;
  logic            r_wrap_q;

  logic [SIZE-1:0] w_bin_next;
  logic [SIZE-1:0] w_gray_next;
  logic            w_wrap_next;

  // Next-state: load beats en; wrap only from a real step across the end.
  always_comb begin
    w_bin_next  = r_bin_q;
    w_wrap_next = 1'b0;
    if (bus.load) begin
      w_bin_next = bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        w_bin_next  = r_bin_q + SIZE'(1);
        w_wrap_next = &r_bin_q;
      end else begin
        w_bin_next  = r_bin_q - SIZE'(1);
        w_wrap_next = ~|r_bin_q;
      end
    end
  end

  // Gray flop is fed from the next binary value, not decoded from bin_out.
  bin_to_gray #(
    .SIZE(SIZE)
  ) u_bin_to_gray (
    .i_bin (w_bin_next),
    .o_gray(w_gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_q  <= RESET_BIN;
      r_gray_q <= RESET_GRAY;
      r_wrap_q <= 1'b0;
    end else begin
      r_bin_q  <= w_bin_next;
      r_gray_q <= w_gray_next;
      r_wrap_q <= w_wrap_next;
    end
  end

  assign bus.bin_out  = r_bin_q;
  assign bus.gray_out = r_gray_q;
  assign bus.wrap     = r_wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - directed and random checks of gray_counter
module tb_gray_counter;
  import gray_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  gray_counter_if #(.SIZE(4)) bus0 ();
  gray_counter_if #(.SIZE(4)) bus5 ();

  gray_counter #(.SIZE(4), .RESET_VAL(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gray_counter #(.SIZE(4), .RESET_VAL(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  logic [3:0] gray_tab [16];

  initial begin
    gray_tab[0]  = 4'b0000; gray_tab[1]  = 4'b0001; gray_tab[2]  = 4'b0011; gray_tab[3]  = 4'b0010;
    gray_tab[4]  = 4'b0110; gray_tab[5]  = 4'b0111; gray_tab[6]  = 4'b0101; gray_tab[7]  = 4'b0100;
    gray_tab[8]  = 4'b1100; gray_tab[9]  = 4'b1101; gray_tab[10] = 4'b1111; gray_tab[11] = 4'b1110;
    gray_tab[12] = 4'b1010; gray_tab[13] = 4'b1011; gray_tab[14] = 4'b1001; gray_tab[15] = 4'b1000;
  end

  task automatic drive(input logic en, input logic up, input logic load, input logic [3:0] val);
    bus0.en = en; bus0.up = up; bus0.load = load; bus0.load_val = val;
    bus5.en = en; bus5.up = up; bus5.load = load; bus5.load_val = val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    step();
    rst = 1'b0;
    n_checks++; if (bus0.bin_out !== 4'b0000) begin n_fail++; $display("FAIL reset_bin0 got %b exp 0000", bus0.bin_out); end
    n_checks++; if (bus0.gray_out !== 4'b0000) begin n_fail++; $display("FAIL reset_gray0 got %b exp 0000", bus0.gray_out); end
    n_checks++; if (bus0.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap0 got %b exp 0", bus0.wrap); end
    n_checks++; if (bus5.bin_out !== 4'b0101) begin n_fail++; $display("FAIL reset_bin5 got %b exp 0101", bus5.bin_out); end
    n_checks++; if (bus5.gray_out !== 4'b0111) begin n_fail++; $display("FAIL reset_gray5 got %b exp 0111", bus5.gray_out); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus0.bin_out !== 4'b0000 || bus0.gray_out !== 4'b0000 || bus0.wrap !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold cyc %0d got bin %b gray %b wrap %b exp 0000/0000/0", i, bus0.bin_out, bus0.gray_out, bus0.wrap);
      end
    end
  endtask

  task automatic test_count_up();
    logic [3:0] eb;
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 1; i <= 16; i++) begin
      step();
      eb = 4'(i);
      n_checks++;
      if (bus0.bin_out !== eb || bus0.gray_out !== gray_tab[eb] || bus0.wrap !== (i == 16)) begin
        n_fail++; $display("FAIL count_up step %0d got bin %b gray %b wrap %b exp %b/%b/%b",
                           i, bus0.bin_out, bus0.gray_out, bus0.wrap, eb, gray_tab[eb], (i == 16));
      end
    end
  endtask

  task automatic test_count_down();
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    step();
    n_checks++;
    if (bus0.bin_out !== 4'b1111 || bus0.gray_out !== 4'b1000 || bus0.wrap !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap got bin %b gray %b wrap %b exp 1111/1000/1", bus0.bin_out, bus0.gray_out, bus0.wrap);
    end
    step();
    n_checks++;
    if (bus0.bin_out !== 4'b1110 || bus0.gray_out !== 4'b1001 || bus0.wrap !== 1'b0) begin
      n_fail++; $display("FAIL down_step got bin %b gray %b wrap %b exp 1110/1001/0", bus0.bin_out, bus0.gray_out, bus0.wrap);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    step();
    n_checks++;
    if (bus0.bin_out !== 4'b1110 || bus0.gray_out !== 4'b1001 || bus0.wrap !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold got bin %b gray %b wrap %b exp 1110/1001/0", bus0.bin_out, bus0.gray_out, bus0.wrap);
    end
  endtask

  task automatic test_load_priority();
    drive(1'b1, 1'b1, 1'b1, 4'b1010);
    step();
    n_checks++;
    if (bus0.bin_out !== 4'b1010 || bus0.gray_out !== 4'b1111 || bus0.wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_wins got bin %b gray %b wrap %b exp 1010/1111/0", bus0.bin_out, bus0.gray_out, bus0.wrap);
    end
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    step();
    n_checks++;
    if (bus0.bin_out !== 4'b1011 || bus0.gray_out !== 4'b1110 || bus0.wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_then_up got bin %b gray %b wrap %b exp 1011/1110/0", bus0.bin_out, bus0.gray_out, bus0.wrap);
    end
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    step();
    drive(1'b1, 1'b1, 1'b1, 4'b0000);
    step();
    n_checks++;
    if (bus0.bin_out !== 4'b0000 || bus0.gray_out !== 4'b0000 || bus0.wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_zero_nowrap got bin %b gray %b wrap %b exp 0000/0000/0", bus0.bin_out, bus0.gray_out, bus0.wrap);
    end
    drive(1'b1, 1'b0, 1'b1, 4'b1111);
    step();
    n_checks++;
    if (bus0.bin_out !== 4'b1111 || bus0.gray_out !== 4'b1000 || bus0.wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_max_nowrap got bin %b gray %b wrap %b exp 1111/1000/0", bus0.bin_out, bus0.gray_out, bus0.wrap);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b1, 4'b0111);
    step();
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus0.bin_out !== 4'b0000 || bus0.gray_out !== 4'b0000 || bus0.wrap !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid0 got bin %b gray %b wrap %b exp 0000/0000/0", bus0.bin_out, bus0.gray_out, bus0.wrap);
    end
    n_checks++;
    if (bus5.bin_out !== 4'b0101 || bus5.gray_out !== 4'b0111 || bus5.wrap !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid5 got bin %b gray %b wrap %b exp 0101/0111/0", bus5.bin_out, bus5.gray_out, bus5.wrap);
    end
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    step();
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus0.bin_out !== 4'b0000 || bus0.wrap !== 1'b0) begin
      n_fail++; $display("FAIL rst_over_wrap got bin %b wrap %b exp 0000/0", bus0.bin_out, bus0.wrap);
    end
  endtask

  task automatic test_dir_change();
    logic [3:0] exp_b [4];
    logic       exp_w [4];
    logic       dir   [4];
    dir[0] = 1'b1; exp_b[0] = 4'h1; exp_w[0] = 1'b0;
    dir[1] = 1'b0; exp_b[1] = 4'h0; exp_w[1] = 1'b0;
    dir[2] = 1'b0; exp_b[2] = 4'hF; exp_w[2] = 1'b1;
    dir[3] = 1'b1; exp_b[3] = 4'h0; exp_w[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, dir[i], 1'b0, 4'h0);
      step();
      n_checks++;
      if (bus0.bin_out !== exp_b[i] || bus0.gray_out !== gray_tab[exp_b[i]] || bus0.wrap !== exp_w[i]) begin
        n_fail++; $display("FAIL dir_change %0d got bin %b gray %b wrap %b exp %b/%b/%b",
                           i, bus0.bin_out, bus0.gray_out, bus0.wrap, exp_b[i], gray_tab[exp_b[i]], exp_w[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] m_bin;
    logic       m_wrap;
    logic [3:0] prev_gray;
    logic       en, up, ld;
    logic [3:0] val;
    m_bin = bus0.bin_out;
    for (int c = 0; c < 10000; c++) begin
      en  = 1'($urandom_range(0, 1));
      up  = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 7) == 0);
      val = 4'($urandom_range(0, 15));
      prev_gray = bus0.gray_out;
      drive(en, up, ld, val);
      m_wrap = 1'b0;
      if (ld) m_bin = val;
      else if (en && up) begin m_wrap = (m_bin == 4'hF); m_bin = m_bin + 4'h1; end
      else if (en) begin m_wrap = (m_bin == 4'h0); m_bin = m_bin - 4'h1; end
      step();
      n_checks++;
      if (bus0.bin_out !== m_bin || bus0.wrap !== m_wrap) begin
        n_fail++; $display("FAIL rand_model cyc %0d got bin %b wrap %b exp %b/%b", c, bus0.bin_out, bus0.wrap, m_bin, m_wrap);
      end
      n_checks++;
      if (bus0.gray_out !== gray_tab[bus0.bin_out]) begin
        n_fail++; $display("FAIL rand_gray cyc %0d got %b exp %b", c, bus0.gray_out, gray_tab[bus0.bin_out]);
      end
      n_checks++;
      if (4'(gray2bin(32'(bus0.gray_out))) !== bus0.bin_out) begin
        n_fail++; $display("FAIL rand_decode cyc %0d got %b exp %b", c, 4'(gray2bin(32'(bus0.gray_out))), bus0.bin_out);
      end
      if (en && !ld) begin
        n_checks++;
        if ($countones(bus0.gray_out ^ prev_gray) != 1) begin
          n_fail++; $display("FAIL rand_hamming cyc %0d got %b from %b exp one bit change", c, bus0.gray_out, prev_gray);
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    test_reset();
    test_count_up();
    test_count_down();
    test_load_priority();
    test_reset_mid();
    test_dir_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
